// File: rtl/pipeline_pkg.sv
// Shared types and control encodings for the 5-stage pipeline hazard controller.
package pipeline_pkg;

   localparam int DEF_REG_ADDR_W = 5;

   typedef enum logic [1:0] {
      FWD_RF     = 2'b00,
      FWD_MEM_WB = 2'b01,
      FWD_EX_MEM = 2'b10
   } fwd_sel_t;

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } hz_state_t;

   typedef struct packed {
      logic pc_write;
      logic if_id_write;
      logic id_ex_write;
      logic ex_mem_write;
      logic mem_wb_write;
      logic if_id_flush;
      logic id_ex_flush;
      logic ex_mem_flush;
   } hz_ctrl_t;

   // Bit order follows hz_ctrl_t: five enables, then three flushes.
   localparam hz_ctrl_t CTRL_RESET    = hz_ctrl_t'(8'b00000_111);
   localparam hz_ctrl_t CTRL_FREEZE   = hz_ctrl_t'(8'b00000_000);
   localparam hz_ctrl_t CTRL_BRANCH   = hz_ctrl_t'(8'b11111_111);
   localparam hz_ctrl_t CTRL_LOAD_USE = hz_ctrl_t'(8'b00111_010);
   localparam hz_ctrl_t CTRL_NORMAL   = hz_ctrl_t'(8'b11111_000);

endpackage

// File: rtl/pipeline_hazard_controller_forwarding_unit.sv
// EX-stage operand forwarding selects; purely combinational, EX/MEM has priority.
module forwarding_unit
   import pipeline_pkg::*;
#(
   parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
   input  logic [REG_ADDR_W-1:0] id_ex_rs1,
   input  logic [REG_ADDR_W-1:0] id_ex_rs2,
   input  logic [REG_ADDR_W-1:0] ex_mem_rd,
   input  logic [REG_ADDR_W-1:0] mem_wb_rd,
   input  logic                  ex_mem_reg_write,
   input  logic                  mem_wb_reg_write,
   output fwd_sel_t              forward_a,
   output fwd_sel_t              forward_b
);

   logic [REG_ADDR_W-1:0] rs  [2];
   fwd_sel_t              sel [2];
   logic                  ex_mem_live;
   logic                  mem_wb_live;

   // x0 is hardwired zero, so a producer targeting it never forwards.
   assign ex_mem_live = ex_mem_reg_write && (ex_mem_rd != '0);
   assign mem_wb_live = mem_wb_reg_write && (mem_wb_rd != '0);

   assign rs[0] = id_ex_rs1;
   assign rs[1] = id_ex_rs2;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_operand
         assign sel[gi] = (ex_mem_live && ex_mem_rd == rs[gi]) ? FWD_EX_MEM :
                          (mem_wb_live && mem_wb_rd == rs[gi]) ? FWD_MEM_WB :
                                                                 FWD_RF;
      end
   endgenerate

   assign forward_a = sel[0];
   assign forward_b = sel[1];

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Pipeline sequencing: hazard decode, memory-wait FSM with watchdog, perf counters.
module pipeline_hazard_controller
   import pipeline_pkg::*;
#(
   parameter int REG_ADDR_W = DEF_REG_ADDR_W,
   parameter int MAX_WAIT   = 16,
   parameter int CNT_W      = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic [REG_ADDR_W-1:0] id_ex_rs1,
   input  logic [REG_ADDR_W-1:0] id_ex_rs2,
   input  logic [REG_ADDR_W-1:0] id_ex_rd,
   input  logic                  id_ex_mem_read,
   input  logic [REG_ADDR_W-1:0] ex_mem_rd,
   input  logic [REG_ADDR_W-1:0] mem_wb_rd,
   input  logic                  ex_mem_reg_write,
   input  logic                  mem_wb_reg_write,
   input  logic                  branch_taken,
   input  logic                  mem_req,
   input  logic                  mem_ready,
   output logic                  pc_write,
   output logic                  if_id_write,
   output logic                  id_ex_write,
   output logic                  ex_mem_write,
   output logic                  mem_wb_write,
   output logic                  if_id_flush,
   output logic                  id_ex_flush,
   output logic                  ex_mem_flush,
   output logic [1:0]            forward_a,
   output logic [1:0]            forward_b,
   output logic                  mem_timeout,
   output logic [CNT_W-1:0]      stall_cycles,
   output logic [CNT_W-1:0]      flush_count
);

   localparam int                WAIT_W   = $clog2(MAX_WAIT + 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

   logic             freeze;
   logic             load_use;
   logic             branch_act;
   logic             load_use_act;
   hz_ctrl_t         ctrl;
   fwd_sel_t         fwd_a;
   fwd_sel_t         fwd_b;

   hz_state_t        state_q;
   logic [WAIT_W-1:0] wait_cnt_q;
   logic             mem_timeout_q;
   logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
   logic [CNT_W-1:0] flush_count_q,  flush_count_d;

   assign freeze   = mem_req && !mem_ready;
   assign load_use = id_ex_mem_read && (id_ex_rd != '0) &&
                     ((id_ex_rd == id_rs1) || (id_ex_rd == id_rs2));

   // A held branch only redirects once memory releases; it also squashes the load-use consumer.
   assign branch_act   = branch_taken && !freeze;
   assign load_use_act = load_use && !freeze && !branch_taken;

   always_comb begin
      ctrl = CTRL_NORMAL;
      if (reset)             ctrl = CTRL_RESET;
      else if (freeze)       ctrl = CTRL_FREEZE;
      else if (branch_taken) ctrl = CTRL_BRANCH;
      else if (load_use)     ctrl = CTRL_LOAD_USE;
   end

   assign pc_write     = ctrl.pc_write;
   assign if_id_write  = ctrl.if_id_write;
   assign id_ex_write  = ctrl.id_ex_write;
   assign ex_mem_write = ctrl.ex_mem_write;
   assign mem_wb_write = ctrl.mem_wb_write;
   assign if_id_flush  = ctrl.if_id_flush;
   assign id_ex_flush  = ctrl.id_ex_flush;
   assign ex_mem_flush = ctrl.ex_mem_flush;

   forwarding_unit #(
      .REG_ADDR_W(REG_ADDR_W)
   ) u_forwarding_unit (
      .id_ex_rs1       (id_ex_rs1),
      .id_ex_rs2       (id_ex_rs2),
      .ex_mem_rd       (ex_mem_rd),
      .mem_wb_rd       (mem_wb_rd),
      .ex_mem_reg_write(ex_mem_reg_write),
      .mem_wb_reg_write(mem_wb_reg_write),
      .forward_a       (fwd_a),
      .forward_b       (fwd_b)
   );

   assign forward_a = reset ? FWD_RF : fwd_a;
   assign forward_b = reset ? FWD_RF : fwd_b;

   // Watchdog counts only cycles spent stuck in MEM_WAIT; the freeze itself is never broken.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= RUN;
         wait_cnt_q    <= '0;
         mem_timeout_q <= 1'b0;
      end else begin
         case (state_q)
            RUN: begin
               wait_cnt_q <= '0;
               if (freeze) state_q <= MEM_WAIT;
            end
            MEM_WAIT: begin
               if (freeze) begin
                  if (wait_cnt_q != WAIT_MAX) wait_cnt_q <= wait_cnt_q + 1'b1;
                  if (wait_cnt_q >= WAIT_MAX - 1'b1) mem_timeout_q <= 1'b1;
               end else begin
                  state_q    <= RUN;
                  wait_cnt_q <= '0;
               end
            end
            default: begin
               state_q    <= RUN;
               wait_cnt_q <= '0;
            end
         endcase
      end
   end

   assign mem_timeout = mem_timeout_q;

   always_comb begin
      stall_cycles_d = stall_cycles_q;
      flush_count_d  = flush_count_q;
      if ((freeze || load_use_act) && (stall_cycles_q != '1))
         stall_cycles_d = stall_cycles_q + 1'b1;
      if (branch_act && (flush_count_q != '1))
         flush_count_d = flush_count_q + 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cycles_q <= '0;
         flush_count_q  <= '0;
      end else begin
         stall_cycles_q <= stall_cycles_d;
         flush_count_q  <= flush_count_d;
      end
   end

   assign stall_cycles = stall_cycles_q;
   assign flush_count  = flush_count_q;

endmodule

// File: doc/pipeline_hazard_controller.md
# pipeline_hazard_controller

Central sequencing block for the 5-stage 64-bit pipeline. It drives write-enable and flush controls for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It detects load-use hazards, taken-branch redirects and data-memory wait states, and generates EX-stage forwarding selects. It also keeps a memory-wait watchdog and performance counters.

## Interface
Parameters:
- REG_ADDR_W, 5: register index width
- MAX_WAIT, 16: data-memory wait cycles before `mem_timeout` is raised
- CNT_W, 32: performance counter width

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-high reset
- id_rs1, id_rs2  in  REG_ADDR_W  source registers of the instruction in ID
- id_ex_rs1, id_ex_rs2  in  REG_ADDR_W  source registers of the instruction in EX
- id_ex_rd  in  REG_ADDR_W  destination of the instruction in EX
- id_ex_mem_read  in  1  instruction in EX is a load
- ex_mem_rd, mem_wb_rd  in  REG_ADDR_W  destinations in MEM / WB
- ex_mem_reg_write, mem_wb_reg_write  in  1  MEM / WB instruction writes the register file
- branch_taken  in  1  taken branch resolved in MEM
- mem_req  in  1  MEM stage is accessing data memory
- mem_ready  in  1  data memory completes this cycle
- pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write  out  1  register enables
- if_id_flush, id_ex_flush, ex_mem_flush  out  1  insert bubble (synchronous clear at the next edge)
- forward_a, forward_b  out  2  ALU operand select: 00 register file, 10 EX/MEM, 01 MEM/WB
- mem_timeout  out  1  sticky watchdog error
- stall_cycles, flush_count  out  CNT_W  saturating performance counters

## Operation
- Condition `freeze` = `mem_req && !mem_ready`.
- Condition `load_use` = `id_ex_mem_read && id_ex_rd!=0 && (id_ex_rd==id_rs1 || id_ex_rd==id_rs2)`.
- Controls are combinational from these conditions. Priority is freeze > branch > load_use > normal.
- **freeze**:
  - All five enables are 0 and all flushes are 0.
  - `branch_taken` stays held in EX/MEM and is acted on in the first unfrozen cycle.
- **branch**:
  - All enables are 1.
  - `if_id_flush`, `id_ex_flush` and `ex_mem_flush` are 1.
  - The load-use stall is suppressed, because that instruction is squashed.
- **load_use**:
  - `pc_write` and `if_id_write` are 0 and `id_ex_flush` is 1.
  - `ex_mem_write` and `mem_wb_write` are 1.
  - Exactly one bubble is inserted.
- **normal**: all enables are 1 and all flushes are 0.
- **Forwarding** (per operand, `forward_a` using `id_ex_rs1`, `forward_b` using `id_ex_rs2`):
  - 10 if `ex_mem_reg_write && ex_mem_rd!=0 && ex_mem_rd==rs`.
  - Otherwise 01 if the same condition holds for MEM/WB.
  - Otherwise 00.
  - EX/MEM wins when both match. x0 is never forwarded.
  - Forwarding is independent of the FSM.
- **FSM**, states RUN and MEM_WAIT:
  - RUN → MEM_WAIT on `freeze`.
  - MEM_WAIT stays while `freeze`. MEM_WAIT → RUN in the cycle `mem_ready`=1 (or `mem_req` drops).
  - `wait_cnt` is cleared on RUN and increments each MEM_WAIT cycle. It saturates at MAX_WAIT.
  - When `wait_cnt` reaches MAX_WAIT, `mem_timeout` is set. It clears only on reset. The freeze continues.
- **Counters**:
  - `stall_cycles` increments on each freeze or load_use cycle.
  - `flush_count` increments on each branch cycle.
  - Both saturate at all-ones.

## Timing
- **Reset** (asynchronous, immediate):
  - The enables, forward selects, `mem_timeout` and counters are forced to 0, and the flushes to 1. While reset is asserted the enables read 0 and the flushes read 1, overriding the combinational decode.
  - State is RUN.
  - Normal decode starts in the first cycle after deassertion.
- Controls are zero-latency: they are valid in the cycle the condition appears and act at the next edge.
- A load-use stall lasts exactly 1 cycle. The following cycle sees the load in MEM, so forwarding resolves it via MEM/WB.
- A freeze lasting N cycles adds N to `stall_cycles`. The release cycle is not counted.
- Freeze coinciding with load_use: freeze wins. The load-use stall occurs in the first unfrozen cycle.
- Reset asserted mid-MEM_WAIT: state returns to RUN, and `wait_cnt` and `mem_timeout` are cleared.

## Structure
- Shared package `pipeline_pkg`:
  - `fwd_sel_t` enum (FWD_RF=00, FWD_MEM_WB=01, FWD_EX_MEM=10)
  - `hz_state_t` (RUN, MEM_WAIT)
  - REG_ADDR_W default
- One sub-module, `forwarding_unit` (purely combinational, produces `forward_a`/`forward_b`). Hazard decode, FSM, watchdog and counters stay in the top.

## Test plan
- Load x5 in EX (`id_ex_mem_read`=1, `id_ex_rd`=5), `id_rs2`=5 → one cycle with `pc_write`=0, `if_id_write`=0, `id_ex_flush`=1, and `stall_cycles` goes 0→1. With `id_ex_rd`=0 → no stall.
- `branch_taken`=1 together with the load-use condition → all enables 1, three flushes 1, `flush_count`=1, no stall counted.
- `mem_req`=1, `mem_ready`=0 for 3 cycles then 1 → enables 0 for exactly 3 cycles, state MEM_WAIT then RUN, `stall_cycles`=3.
- MAX_WAIT=4, `mem_ready` held 0 → `mem_timeout` rises after 4 MEM_WAIT cycles and stays 1 after `mem_ready`. Reset clears it.
- `ex_mem_rd`=`mem_wb_rd`=7, both reg_write=1, `id_ex_rs1`=7 → `forward_a`=10. Drop `ex_mem_reg_write` → 01. With rd=0 → 00.
- Assert reset mid-MEM_WAIT → flushes immediately 1, counters 0, RUN after release.
